pps_ts_ctrl: RTL and testbench

Capture controller for the PPS input timestamp path in the RTC subsystem. It synchronises `pps_i`, detects the selected edge, and samples the running RTC time. It then removes the fixed two-cycle detection latency (2×tick increment) and queues corrected timestamps in a small show-ahead FIFO that software drains by read strobe. A programmable holdoff rejects glitches and bounce, and overflow and interrupt reporting are included.

---
 rtl/pps_ts_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pps_ts_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pps_ts_ctrl.sv
// PPS timestamp capture controller: synchronises pps_i, captures RTC time on the selected edge,
// removes the two-tick detection latency and queues corrected stamps in a show-ahead FIFO.
module pps_ts_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3,
  parameter logic [31:0] SC2NS = 32'd1000000000
) (
  input  logic              rtc_clk,
  input  logic              rtc_rst_n,
  input  logic              enable_i,
  input  logic              edge_sel_i,
  input  logic [31:0]       tick_inc_i,
  input  logic [79:0]       rtc_std_i,
  input  logic [15:0]       rtc_fns_i,
  input  logic [15:0]       holdoff_cyc_i,
  input  logic              pps_i,
  input  logic              rd_req_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  input  logic              irq_en_i,
  output logic              ts_valid_o,
  output logic [79:0]       ts_std_o,
  output logic [15:0]       ts_fns_o,
  output logic [CNT_W-1:0]  fifo_cnt_o,
  output logic              ovf_o,
  output logic              irq_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, CAPT, WRITE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               s1, s2, s3;
  logic               edge_det;
  logic [15:0]        hold_cnt_q;
  logic [47:0]        raw_sec_q;
  logic [31:0]        raw_ns_q;
  logic [15:0]        raw_fns_q;
  logic [95:0]        cor_q;
  logic [47:0]        corr;
  logic [48:0]        diff;
  logic               borrow;
  logic [95:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               full, empty, push, pop, ovf_set;
  logic               ovf_q, irq_q;
  logic [95:0]        head;

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pps_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = edge_sel_i ? (~s2 & s3) : (s2 & ~s3);

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (edge_det) state_d = CAPT;
        CAPT:    state_d = WRITE;
        WRITE:   state_d = (holdoff_cyc_i != 16'd0) ? HOLD : ARMED;
        HOLD:    if (hold_cnt_q == holdoff_cyc_i - 16'd1) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n)              hold_cnt_q <= '0;
    else if (state_q == WRITE)   hold_cnt_q <= '0;
    else if (state_q == HOLD)    hold_cnt_q <= hold_cnt_q + 16'd1;
  end

  // Two ticks in 6.26 ns rescaled to 32.16 ns; a borrow pulls one second into the ns field.
  assign corr   = 48'({tick_inc_i, 1'b0}) >> 10;
  assign diff   = {1'b0, raw_ns_q, raw_fns_q} - {1'b0, corr};
  assign borrow = diff[48];

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      raw_sec_q <= '0;
      raw_ns_q  <= '0;
      raw_fns_q <= '0;
      cor_q     <= '0;
    end else begin
      if (state_q == ARMED && edge_det && enable_i) begin
        raw_sec_q <= rtc_std_i[79:32];
        raw_ns_q  <= rtc_std_i[31:0];
        raw_fns_q <= rtc_fns_i;
      end
      if (state_q == CAPT) begin
        cor_q <= {raw_sec_q - (borrow ? 48'd1 : 48'd0),
                  diff[47:16] + (borrow ? SC2NS : 32'd0),
                  diff[15:0]};
      end
    end
  end

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = rd_req_i & ~empty;
  assign push    = (state_q == WRITE) & enable_i & (~full | pop);
  assign ovf_set = (state_q == WRITE) & enable_i & full & ~pop & ~flush_i;

  // NOTE: storage is reset because the head is visible on the outputs straight after reset.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= cor_q;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
      irq_q <= ~empty & irq_en_i;
    end
  end

  assign head       = mem[rd_ptr_q];
  assign ts_std_o   = head[95:16];
  assign ts_fns_o   = head[15:0];
  assign ts_valid_o = ~empty;
  assign fifo_cnt_o = cnt_q;
  assign ovf_o      = ovf_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_pps_ts_ctrl.sv
// Directed bench for pps_ts_ctrl: capture latency, correction borrow/wrap, FIFO overflow,
// simultaneous push/pop, holdoff, enable/flush/reset control and falling-edge selection.
module tb_pps_ts_ctrl;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst_n;
  logic        enable_i, edge_sel_i, pps_i, rd_req_i, flush_i, ovf_clr_i, irq_en_i;
  logic [31:0] tick_inc_i;
  logic [79:0] rtc_std_i;
  logic [15:0] rtc_fns_i, holdoff_cyc_i;
  logic        ts_valid_o, ovf_o, irq_o;
  logic [79:0] ts_std_o;
  logic [15:0] ts_fns_o;
  logic [2:0]  fifo_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  pps_ts_ctrl #(.DEPTH(4), .CNT_W(3), .SC2NS(32'd1000000000)) dut (
    .rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n), .enable_i(enable_i), .edge_sel_i(edge_sel_i),
    .tick_inc_i(tick_inc_i), .rtc_std_i(rtc_std_i), .rtc_fns_i(rtc_fns_i),
    .holdoff_cyc_i(holdoff_cyc_i), .pps_i(pps_i), .rd_req_i(rd_req_i), .flush_i(flush_i),
    .ovf_clr_i(ovf_clr_i), .irq_en_i(irq_en_i), .ts_valid_o(ts_valid_o), .ts_std_o(ts_std_o),
    .ts_fns_o(ts_fns_o), .fifo_cnt_o(fifo_cnt_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rtc_clk);
  endtask

  // Rising toggle on pps_i; returns at the negedge after the FIFO push edge.
  task automatic capture();
    pps_i = 1'b1;
    cyc(3);
    pps_i = 1'b0;
    cyc(2);
  endtask

  task automatic pop();
    rd_req_i = 1'b1;
    cyc(1);
    rd_req_i = 1'b0;
  endtask

  function automatic logic [79:0] std(input logic [47:0] sec, input logic [31:0] ns);
    return {sec, ns};
  endfunction

  initial begin
    rtc_rst_n = 1'b0; enable_i = 1'b0; edge_sel_i = 1'b0; pps_i = 1'b0; rd_req_i = 1'b0;
    flush_i = 1'b0; ovf_clr_i = 1'b0; irq_en_i = 1'b1; tick_inc_i = 32'h1000_0000;
    rtc_std_i = '0; rtc_fns_i = '0; holdoff_cyc_i = 16'd0;
    cyc(2);
    check("rst_valid", ts_valid_o, 0);
    check("rst_cnt", fifo_cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_std", ts_std_o, 0);
    check("rst_fns", ts_fns_o, 0);
    rtc_rst_n = 1'b1;
    enable_i  = 1'b1;
    cyc(2);

    // Rising-edge capture and latency
    rtc_std_i = std(48'd5, 32'd1000);
    pps_i = 1'b1;
    cyc(4);
    check("lat_valid_pre", ts_valid_o, 0);
    cyc(1);
    check("lat_valid", ts_valid_o, 1);
    check("lat_cnt", fifo_cnt_o, 1);
    check("lat_std", ts_std_o, std(48'd5, 32'd992));
    check("lat_fns", ts_fns_o, 16'h0000);
    check("lat_irq_pre", irq_o, 0);
    cyc(1);
    check("lat_irq", irq_o, 1);
    pps_i = 1'b0;
    cyc(3);
    pop();
    check("pop_empty", ts_valid_o, 0);
    check("pop_cnt", fifo_cnt_o, 0);

    // Borrow
    rtc_std_i = std(48'd7, 32'd4);
    capture();
    check("borrow_std", ts_std_o, std(48'd6, 32'd999_999_996));
    pop();
    cyc(1);

    // Borrow with second wrap and fractional part: 4.5 ns - 8 ns
    rtc_std_i = std(48'd0, 32'd4);
    rtc_fns_i = 16'h8000;
    capture();
    check("wrap_std", ts_std_o, std(48'hFFFF_FFFF_FFFF, 32'd999_999_996));
    check("wrap_fns", ts_fns_o, 16'h8000);
    rtc_fns_i = 16'h0000;
    pop();
    cyc(1);

    // Overflow: five captures, no reads
    for (int i = 0; i < 5; i++) begin
      rtc_std_i = std(48'(10 + i), 32'd1000);
      capture();
      cyc(1);
    end
    check("ovf_cnt", fifo_cnt_o, 4);
    check("ovf_set", ovf_o, 1);
    check("ovf_head", ts_std_o, std(48'd10, 32'd992));
    ovf_clr_i = 1'b1;
    cyc(1);
    ovf_clr_i = 1'b0;
    check("ovf_clr", ovf_o, 0);
    check("ovf_cnt_kept", fifo_cnt_o, 4);

    // Full FIFO: pop in the WRITE cycle
    rtc_std_i = std(48'd20, 32'd1000);
    pps_i = 1'b1;
    cyc(4);
    rd_req_i = 1'b1;
    cyc(1);
    rd_req_i = 1'b0;
    pps_i = 1'b0;
    check("pp_cnt", fifo_cnt_o, 4);
    check("pp_ovf", ovf_o, 0);
    check("pp_head1", ts_std_o, std(48'd11, 32'd992));
    pop();
    check("pp_head2", ts_std_o, std(48'd12, 32'd992));
    pop();
    check("pp_head3", ts_std_o, std(48'd13, 32'd992));
    pop();
    check("pp_last", ts_std_o, std(48'd20, 32'd992));
    check("pp_cnt_last", fifo_cnt_o, 1);
    pop();
    check("pp_drained", fifo_cnt_o, 0);
    cyc(2);

    // Enable dropped while in CAPT
    rtc_std_i = std(48'd25, 32'd1000);
    pps_i = 1'b1;
    cyc(3);
    enable_i = 1'b0;
    cyc(1);
    enable_i = 1'b1;
    pps_i = 1'b0;
    cyc(6);
    check("en_drop_cnt", fifo_cnt_o, 0);
    check("en_drop_valid", ts_valid_o, 0);

    // Flush with three entries
    for (int i = 0; i < 3; i++) begin
      capture();
      cyc(1);
    end
    check("flush_pre_cnt", fifo_cnt_o, 3);
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    check("flush_valid", ts_valid_o, 0);
    check("flush_cnt", fifo_cnt_o, 0);
    cyc(2);

    // Holdoff of 100 cycles: edges at 0, 50, 200
    holdoff_cyc_i = 16'd100;
    rtc_std_i = std(48'd30, 32'd1000);
    pps_i = 1'b1; cyc(3); pps_i = 1'b0; cyc(47);
    rtc_std_i = std(48'd31, 32'd1000);
    pps_i = 1'b1; cyc(3); pps_i = 1'b0; cyc(147);
    rtc_std_i = std(48'd32, 32'd1000);
    pps_i = 1'b1; cyc(3); pps_i = 1'b0; cyc(10);
    check("hold_cnt", fifo_cnt_o, 2);
    check("hold_head", ts_std_o, std(48'd30, 32'd992));
    pop();
    check("hold_second", ts_std_o, std(48'd32, 32'd992));
    check("hold_irq", irq_o, 1);

    // Asynchronous reset while in HOLD
    edge_sel_i = 1'b1;
    #1 rtc_rst_n = 1'b0;
    #1;
    check("arst_valid", ts_valid_o, 0);
    check("arst_cnt", fifo_cnt_o, 0);
    check("arst_ovf", ovf_o, 0);
    check("arst_irq", irq_o, 0);
    check("arst_std", ts_std_o, 0);
    check("arst_fns", ts_fns_o, 0);
    cyc(2);
    rtc_rst_n = 1'b1;
    holdoff_cyc_i = 16'd0;
    cyc(2);

    // Falling-edge selection
    rtc_std_i = std(48'd40, 32'd1000);
    pps_i = 1'b1;
    cyc(8);
    check("fall_rise_ignored", fifo_cnt_o, 0);
    rtc_std_i = std(48'd41, 32'd1000);
    pps_i = 1'b0;
    cyc(5);
    check("fall_cnt", fifo_cnt_o, 1);
    check("fall_std", ts_std_o, std(48'd41, 32'd992));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
